// File: rtl/toggle_pkg.sv
// Shared types and constants for the toggle (running-XOR) line decoder.
package toggle_pkg;

    localparam int unsigned WordWDefault = 12;

    typedef enum logic [0:0] {
        StCollect = 1'b0,
        StParity  = 1'b1
    } toggle_state_e;

    // Counter must also represent WORD_W itself while the parity slot is pending.
    function automatic int unsigned cnt_width(input int unsigned word_w);
        return $clog2(word_w + 1);
    endfunction

endpackage

// File: rtl/toggle_bit_decoder.sv
// Per-bit stage: recovers each data bit as q XOR the previously sampled line level.
module toggle_bit_decoder (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic q,
    output logic dec_bit,
    output logic bit_out,
    output logic bit_valid
);

    logic prev_q_q, prev_q_d;
    logic bit_out_q, bit_out_d;
    logic bit_valid_q, bit_valid_d;

    assign dec_bit = q ^ prev_q_q;

    always_comb begin
        prev_q_d    = prev_q_q;
        bit_out_d   = bit_out_q;
        bit_valid_d = 1'b0;
        if (en) begin
            prev_q_d    = q;
            bit_out_d   = dec_bit;
            bit_valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            prev_q_q    <= 1'b0;
            bit_out_q   <= 1'b0;
            bit_valid_q <= 1'b0;
        end else begin
            prev_q_q    <= prev_q_d;
            bit_out_q   <= bit_out_d;
            bit_valid_q <= bit_valid_d;
        end
    end

    assign bit_out   = bit_out_q;
    assign bit_valid = bit_valid_q;

endmodule

// File: rtl/toggle_decoder.sv
// Toggle-line receiver: assembles decoded bits LSB-first into words on a valid/ready port.
// Optional even-parity slot after each word when PARITY_CHECK_EN is defined.
module toggle_decoder
    import toggle_pkg::*;
#(
    parameter int unsigned WORD_W = WordWDefault
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic              q,
    output logic              bit_out,
    output logic              bit_valid,
    output logic [WORD_W-1:0] out_word,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              overrun,
    output logic              parity_err
);

    localparam int unsigned CntW = cnt_width(WORD_W);

    logic dec_bit;

    toggle_bit_decoder u_bit_decoder (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .q         (q),
        .dec_bit   (dec_bit),
        .bit_out   (bit_out),
        .bit_valid (bit_valid)
    );

    toggle_state_e     state_q, state_d;
    logic [CntW-1:0]   bit_cnt_q, bit_cnt_d;
    logic [WORD_W-1:0] shift_q, shift_d;
    logic [WORD_W-1:0] out_word_q, out_word_d;
    logic              out_valid_q, out_valid_d;
    logic              overrun_q, overrun_d;
    logic              word_done;
`ifdef PARITY_CHECK_EN
    logic              parity_err_q, parity_err_d;
    logic              done_perr;
`endif

    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        shift_d     = shift_q;
        out_word_d  = out_word_q;
        out_valid_d = out_valid_q;
        overrun_d   = overrun_q;
        word_done   = 1'b0;
`ifdef PARITY_CHECK_EN
        parity_err_d = parity_err_q;
        done_perr    = 1'b0;
`endif
        if (en) begin
            unique case (state_q)
                StCollect: begin
                    for (int i = 0; i < int'(WORD_W); i++) begin
                        if (bit_cnt_q == CntW'(i)) begin
                            shift_d[i] = dec_bit;
                        end
                    end
                    if (bit_cnt_q == CntW'(WORD_W - 1)) begin
`ifdef PARITY_CHECK_EN
                        state_d   = StParity;
                        bit_cnt_d = CntW'(WORD_W);
`else
                        word_done = 1'b1;
                        bit_cnt_d = '0;
`endif
                    end else begin
                        bit_cnt_d = bit_cnt_q + CntW'(1);
                    end
                end
`ifdef PARITY_CHECK_EN
                StParity: begin
                    word_done = 1'b1;
                    done_perr = (^shift_q) ^ dec_bit;
                    bit_cnt_d = '0;
                    state_d   = StCollect;
                end
`endif
                default: state_d = StCollect;
            endcase
        end

        // A handshake on the same edge as a completed word frees the slot for it.
        if (word_done) begin
            if (!out_valid_q || out_ready) begin
                out_word_d  = shift_d;
                out_valid_d = 1'b1;
`ifdef PARITY_CHECK_EN
                parity_err_d = done_perr;
`endif
            end else begin
                overrun_d = 1'b1;
            end
        end else if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= StCollect;
            bit_cnt_q   <= '0;
            shift_q     <= '0;
            out_word_q  <= '0;
            out_valid_q <= 1'b0;
            overrun_q   <= 1'b0;
`ifdef PARITY_CHECK_EN
            parity_err_q <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            out_word_q  <= out_word_d;
            out_valid_q <= out_valid_d;
            overrun_q   <= overrun_d;
`ifdef PARITY_CHECK_EN
            parity_err_q <= parity_err_d;
`endif
        end
    end

    assign out_word  = out_word_q;
    assign out_valid = out_valid_q;
    assign overrun   = overrun_q;
`ifdef PARITY_CHECK_EN
    assign parity_err = parity_err_q;
`else
    assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_toggle_decoder.sv
// Bench for toggle_decoder: directed word scenarios plus random line traffic vs. a word-level model.
module tb_toggle_decoder;

    localparam int W = 12;
`ifdef PARITY_CHECK_EN
    localparam int  Frame = W + 1;
    localparam bit  ParOn = 1'b1;
`else
    localparam int  Frame = W;
    localparam bit  ParOn = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         en = 1'b0;
    logic         q = 1'b0;
    logic         out_ready = 1'b0;
    logic         bit_out, bit_valid, out_valid, overrun, parity_err;
    logic [W-1:0] out_word;

    always #5 clk = ~clk;

    toggle_decoder #(.WORD_W(W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (en),
        .q          (q),
        .bit_out    (bit_out),
        .bit_valid  (bit_valid),
        .out_word   (out_word),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .overrun    (overrun),
        .parity_err (parity_err)
    );

    // Word-level model: list of bits of the frame in progress, one held output word.
    bit           m_prev, m_bit_out, m_bit_valid, m_valid, m_ovr, m_perr;
    bit [W-1:0]   m_word;
    bit           m_frame[$];
    bit           chk_on = 1'b0;
    bit           tb_line = 1'b0;
    int           n_vec = 0;
    int           n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_edge(input bit r, input bit e, input bit qq, input bit rdy);
        bit           b;
        bit           loaded;
        bit [W-1:0]   word;
        int           ones;
        if (!r) begin
            m_prev = 0; m_bit_out = 0; m_bit_valid = 0; m_valid = 0;
            m_ovr = 0; m_perr = 0; m_word = '0;
            m_frame.delete();
            return;
        end
        loaded = 0;
        if (e) begin
            b = qq ^ m_prev;
            m_prev = qq;
            m_bit_out = b;
            m_bit_valid = 1;
            m_frame.push_back(b);
            if (m_frame.size() == Frame) begin
                word = '0;
                ones = 0;
                for (int i = 0; i < W; i++) begin
                    if (m_frame[i]) begin
                        word = word + (W'(1) << i);
                        ones++;
                    end
                end
                if (!m_valid || rdy) begin
                    m_word = word;
                    m_perr = ParOn ? (((ones % 2) == 1) != m_frame[W]) : 1'b0;
                    m_valid = 1;
                    loaded = 1;
                end else begin
                    m_ovr = 1;
                end
                m_frame.delete();
            end
        end else begin
            m_bit_valid = 0;
        end
        if (m_valid && rdy && !loaded && r) m_valid = 0;
    endtask

    always @(negedge clk) begin
        if (chk_on) begin
            chk("bit_out", bit_out, m_bit_out);
            chk("bit_valid", bit_valid, m_bit_valid);
            chk("out_valid", out_valid, m_valid);
            chk("overrun", overrun, m_ovr);
            chk("parity_err", parity_err, m_perr);
            if (m_valid) chk("out_word", out_word, m_word);
        end
    end

    task automatic step(input bit r, input bit e, input bit qq, input bit rdy);
        #1;
        rst_n = r; en = e; q = qq; out_ready = rdy;
        @(posedge clk);
        model_edge(r, e, qq, rdy);
    endtask

    task automatic settle();
        #2;
    endtask

    task automatic send_bit(input bit b, input bit rdy);
        tb_line = tb_line ^ b;
        step(1, 1, tb_line, rdy);
    endtask

    task automatic send_par(input logic [W-1:0] word, input bit flip, input bit rdy);
        if (ParOn) send_bit((^word) ^ flip, rdy);
    endtask

    task automatic send_word(input logic [W-1:0] word, input bit flip, input bit rdy);
        for (int i = 0; i < W; i++) send_bit(word[i], rdy);
        send_par(word, flip, rdy);
    endtask

    task automatic consume();
        step(1, 0, tb_line, 1);
    endtask

    initial begin
        logic [W-1:0] exp_bits;
        logic [W-1:0] w5a3;
        w5a3 = 12'h5A3;

        // Reset
        step(0, 0, 0, 0);
        step(0, 0, 0, 0);
        chk_on = 1'b1;
        tb_line = 1'b0;
        settle();
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_word", out_word, 0);
        chk("rst_overrun", overrun, 0);
        chk("rst_bit_out", bit_out, 0);

        // Idle line decodes as an all-zero word
        send_word('0, 0, 0);
        settle();
        chk("idle_valid", out_valid, 1);
        chk("idle_word", out_word, 0);
        consume();
        settle();
        chk("idle_consumed", out_valid, 0);

        // 12'h5A3 with out_ready held high; bit stream pinned literally
        exp_bits = 12'b0101_1010_0011;
        for (int i = 0; i < W; i++) begin
            send_bit(w5a3[i], 1);
            settle();
            chk("seq_bit_out", bit_out, exp_bits[i]);
        end
        send_par(w5a3, 0, 1);
        settle();
        chk("w5a3_word", out_word, 12'h5A3);
        chk("w5a3_valid", out_valid, 1);
        consume();
        settle();
        chk("w5a3_one_cycle", out_valid, 0);

        // en low for three cycles mid-word while the line toggles
        for (int i = 0; i < 6; i++) send_bit(w5a3[i], 0);
        for (int i = 0; i < 3; i++) step(1, 0, (i % 2 == 0) ? ~tb_line : tb_line, 0);
        for (int i = 6; i < W; i++) send_bit(w5a3[i], 0);
        send_par(w5a3, 0, 0);
        settle();
        chk("gap_word", out_word, 12'h5A3);
        consume();

        // Two words into a full slot: second one dropped
        send_word(12'h5A3, 0, 0);
        send_word(12'h3C1, 0, 0);
        settle();
        chk("ovr_word_held", out_word, 12'h5A3);
        chk("ovr_flag", overrun, 1);
        consume();
        settle();
        chk("ovr_consumed", out_valid, 0);
        chk("ovr_sticky", overrun, 1);

        // Reset after five bits, then 12'hFFF
        for (int i = 0; i < 5; i++) send_bit(1'b1, 0);
        step(0, 0, 0, 0);
        tb_line = 1'b0;
        send_word(12'hFFF, 0, 0);
        settle();
        chk("post_rst_word", out_word, 12'hFFF);
        chk("post_rst_overrun", overrun, 0);
        consume();

`ifdef PARITY_CHECK_EN
        send_word(12'h5A3, 0, 0);
        settle();
        chk("par_good", parity_err, 0);
        consume();
        send_word(12'h5A3, 1, 0);
        settle();
        chk("par_bad", parity_err, 1);
        chk("par_bad_word", out_word, 12'h5A3);
        consume();
`else
        settle();
        chk("par_off", parity_err, 0);
`endif

        // Random line traffic with occasional resets
        for (int i = 0; i < 4000; i++) begin
            step(($urandom_range(0, 299) != 0), ($urandom_range(0, 3) != 0),
                 1'($urandom_range(0, 1)), ($urandom_range(0, 4) == 0));
        end

        settle();
        chk_on = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
